// File: rtl/limc_mc.sv
// rtl/limc_mc.sv - multi-channel pipelined A2 coefficient limiter with saturation counters
// Two-stage stall pipeline clamps A2T to +/-LIMIT and counts clamp events per channel.
module limc_mc #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 32,
  parameter int CH_W     = $clog2(CHANNELS),
  parameter int LIMIT    = 12288,
  parameter int CNT_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CH_W-1:0]         in_ch,
  input  logic signed [WIDTH-1:0] a2t,
  input  logic                    bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CH_W-1:0]         out_ch,
  output logic signed [WIDTH-1:0] a2p,
  output logic                    out_sat,
  input  logic [CH_W-1:0]         stat_ch,
  input  logic                    stat_clr,
  output logic [CNT_W-1:0]        stat_cnt,
  input  logic                    scan_in0,
  input  logic                    scan_in1,
  input  logic                    scan_in2,
  input  logic                    scan_in3,
  input  logic                    scan_in4,
  input  logic                    scan_enable,
  input  logic                    test_mode,
  output logic                    scan_out0,
  output logic                    scan_out1,
  output logic                    scan_out2,
  output logic                    scan_out3,
  output logic                    scan_out4
);

  localparam logic signed [WIDTH-1:0] LIM_P = WIDTH'(LIMIT);
  localparam logic signed [WIDTH-1:0] LIM_N = -LIM_P;

  logic                    s1_valid;
  logic signed [WIDTH-1:0] s1_a2t;
  logic [CH_W-1:0]         s1_ch;
  logic                    s1_bypass;
  logic                    en;
  logic signed [WIDTH-1:0] lim_val;
  logic                    lim_sat;
  logic                    fire;
  logic [CNT_W-1:0]        cnt [CHANNELS];

  assign en       = !out_valid || out_ready;
  assign in_ready = en && reset;
  assign fire     = out_valid && out_ready && out_sat;

  always_comb begin
    lim_val = s1_a2t;
    lim_sat = 1'b0;
    if (!s1_bypass) begin
      if (s1_a2t > LIM_P) begin
        lim_val = LIM_P;
        lim_sat = 1'b1;
      end else if (s1_a2t < LIM_N) begin
        lim_val = LIM_N;
        lim_sat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_a2t    <= '0;
      s1_ch     <= '0;
      s1_bypass <= 1'b0;
      out_valid <= 1'b0;
      a2p       <= '0;
      out_ch    <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid && in_ready;
      s1_a2t    <= a2t;
      s1_ch     <= in_ch;
      s1_bypass <= bypass;
      out_valid <= s1_valid;
      a2p       <= lim_val;
      out_ch    <= s1_ch;
      out_sat   <= s1_valid && lim_sat;
    end
  end

  // Clear takes priority but a coincident increment still lands, so the result is 1.
  // Tags at or above CHANNELS match no counter and are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (stat_clr && stat_ch == CH_W'(i))
          cnt[i] <= (fire && out_ch == CH_W'(i)) ? CNT_W'(1) : '0;
        else if (fire && out_ch == CH_W'(i) && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (stat_ch == CH_W'(i)) stat_cnt = cnt[i];
  end

  logic dft_unused;
  assign dft_unused = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
  assign scan_out0  = 1'b0;
  assign scan_out1  = 1'b0;
  assign scan_out2  = 1'b0;
  assign scan_out3  = 1'b0;
  assign scan_out4  = 1'b0;

endmodule

// File: tb/tb_limc_mc.sv
// tb/tb_limc_mc.sv - self-checking bench for limc_mc
// Scoreboard queue filled on input handshakes and drained on output handshakes.
module tb_limc_mc;

  logic        clk = 1'b0;
  logic        reset, in_valid, bypass, out_ready, stat_clr;
  logic [4:0]  in_ch, stat_ch;
  logic [15:0] a2t;
  logic        in_ready, out_valid, out_sat;
  logic [4:0]  out_ch;
  logic [15:0] a2p;
  logic [7:0]  stat_cnt;
  logic [4:0]  so;

  logic        in_valid2;
  logic [4:0]  stat_ch2;
  logic        in_ready2, out_valid2, out_sat2;
  logic [4:0]  out_ch2;
  logic [15:0] a2p2;
  logic [7:0]  stat_cnt2;
  logic [4:0]  so2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  ch;
    logic [15:0] a2p;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic        hold_v = 1'b0;
  logic [21:0] hold_d;

  always #5 clk = ~clk;

  limc_mc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .a2t(a2t), .bypass(bypass), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .a2p(a2p), .out_sat(out_sat), .stat_ch(stat_ch), .stat_clr(stat_clr),
    .stat_cnt(stat_cnt), .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0),
    .scan_in4(1'b0), .scan_enable(1'b0), .test_mode(1'b0), .scan_out0(so[0]),
    .scan_out1(so[1]), .scan_out2(so[2]), .scan_out3(so[3]), .scan_out4(so[4])
  );

  limc_mc #(.CHANNELS(20)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_ch(in_ch),
    .a2t(a2t), .bypass(bypass), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ch(out_ch2), .a2p(a2p2), .out_sat(out_sat2), .stat_ch(stat_ch2), .stat_clr(stat_clr),
    .stat_cnt(stat_cnt2), .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0),
    .scan_in4(1'b0), .scan_enable(1'b0), .test_mode(1'b0), .scan_out0(so2[0]),
    .scan_out1(so2[1]), .scan_out2(so2[2]), .scan_out3(so2[3]), .scan_out4(so2[4])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input logic [4:0] ch, input logic signed [15:0] v,
                                 input logic byp);
    exp_t e;
    e.ch  = ch;
    e.a2p = v;
    e.sat = 1'b0;
    if (!byp) begin
      if (v > 16'sd12288) begin
        e.a2p = 16'h3000;
        e.sat = 1'b1;
      end else if (v < -16'sd12288) begin
        e.a2p = 16'hD000;
        e.sat = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] ch, input logic [7:0] want, input string tag);
    stat_ch = ch;
    #1;
    chk(tag, stat_cnt, want);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk(tag, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (hold_v) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", {out_ch, a2p, out_sat}, hold_d);
    end
    hold_v = reset && out_valid && !out_ready;
    hold_d = {out_ch, a2p, out_sat};
    chk("in_ready", in_ready, reset && (!out_valid || out_ready));
    if (!reset) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready) sb.push_back(model(in_ch, a2t, bypass));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_ch", out_ch, mon_e.ch);
          chk("sb_a2p", a2p, mon_e.a2p);
          chk("sb_sat", out_sat, mon_e.sat);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bvals [6];
    int k, p;
    logic acc;
    reset = 0; in_valid = 0; in_valid2 = 0; bypass = 0; out_ready = 0; stat_clr = 0;
    in_ch = 0; stat_ch = 0; stat_ch2 = 0; a2t = 0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a2p", a2p, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", {in_ready, in_ready2}, 0);
    chk("rst_scan_out", {so, so2}, 0);
    chk("rst_stat_cnt", stat_cnt, 0);

    // single sample, ch 3, two-cycle latency
    reset = 1; out_ready = 1;
    in_valid = 1; in_ch = 3; a2t = 16'h2000;
    tick();
    in_valid = 0;
    chk("lat_early", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_a2p", a2p, 16'h2000);
    chk("lat_ch", out_ch, 3);
    chk("lat_sat", out_sat, 0);
    tick();
    rd(3, 0, "cnt3_zero");

    // clamp boundaries on ch 1
    bvals[0] = 16'h3000; bvals[1] = 16'h3001; bvals[2] = 16'h7FFF;
    bvals[3] = 16'hD000; bvals[4] = 16'hCFFF; bvals[5] = 16'h8000;
    in_ch = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; a2t = bvals[i];
      tick();
    end
    in_valid = 0;
    drain("drain_bound");
    rd(1, 4, "cnt1_bound");

    // 300 clamps on ch 5 interleaved with bypassed samples on ch 6
    for (int i = 0; i < 330; i++) begin
      in_valid = 1;
      if (i % 11 == 10) begin
        in_ch = 6; a2t = 16'h7FFF; bypass = 1;
      end else begin
        in_ch = 5; a2t = (i % 2 == 0) ? 16'h7FFF : 16'h8000; bypass = 0;
      end
      tick();
    end
    in_valid = 0; bypass = 0;
    drain("drain_sat");
    rd(5, 255, "cnt5_sat");
    rd(6, 0, "cnt6_bypass");

    // clear coincident with a clamped transfer on the same channel
    in_valid = 1; in_ch = 5; a2t = 16'h4000;
    tick();
    in_valid = 0;
    tick();
    chk("clr_align", out_valid, 1);
    stat_clr = 1; stat_ch = 5;
    tick();
    stat_clr = 0;
    rd(5, 1, "cnt5_clr_same");

    // clear on another channel while ch 5 counts
    in_valid = 1; in_ch = 5; a2t = 16'hB000;
    tick();
    in_valid = 0;
    tick();
    stat_clr = 1; stat_ch = 1;
    tick();
    stat_clr = 0;
    rd(5, 2, "cnt5_clr_other");
    rd(1, 0, "cnt1_cleared");

    // backpressure: out_ready pattern 1,0,0 while streaming ch 0..9
    k = 0; p = 0;
    in_valid = 1; in_ch = 0; a2t = 16'($urandom);
    for (int t = 0; t < 200 && k < 10; t++) begin
      out_ready = (p % 3 == 0); p++;
      #1;
      acc = in_ready;
      tick();
      if (acc) begin
        k++;
        in_ch = 5'(k); a2t = 16'($urandom);
      end
    end
    in_valid = 0;
    chk("bp_sent", k, 10);
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      out_ready = (p % 3 == 0); p++;
      tick();
    end
    chk("bp_drain", sb.size(), 0);
    out_ready = 1;
    tick();

    // reset with two samples in flight
    in_valid = 1; in_ch = 2; a2t = 16'h7000;
    tick(); tick();
    reset = 0; in_valid = 0;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    tick();
    chk("rst_mid_valid", out_valid, 0);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_no_stale", out_valid, 0);
    end
    for (int i = 0; i < 32; i++) rd(5'(i), 0, "rst_cnt_zero");

    // 20-channel build: out-of-range tag is clamped but never counted
    in_valid2 = 1; in_ch = 25; a2t = 16'h4000;
    tick();
    in_valid2 = 0;
    tick();
    chk("c20_valid", out_valid2, 1);
    chk("c20_a2p", a2p2, 16'h3000);
    chk("c20_sat", out_sat2, 1);
    chk("c20_ch", out_ch2, 25);
    tick();
    for (int i = 0; i < 20; i++) begin
      stat_ch2 = 5'(i);
      #1;
      chk("c20_cnt_zero", stat_cnt2, 0);
    end
    stat_ch2 = 25;
    #1;
    chk("c20_stat_oor", stat_cnt2, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
